// File: rtl/bleeper_pkg.sv
// bleeper_pkg: shared types and constants for the bleeper controller.
//   bleep_state_t  controller FSM state encoding
//   BEEP_ON_CMD    port F8 data value that opens the CPU beep
//   BEEP_OFF_CMD   port F8 data value that closes the CPU beep
//   max_u / safe_clog2  width helpers used for counter sizing
package bleeper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPU_ON,
    TIMED,
    GAP
  } bleep_state_t;

  localparam logic [7:0] BEEP_ON_CMD  = 8'h0B;
  localparam logic [7:0] BEEP_OFF_CMD = 8'h0C;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // $clog2 returns 0 for 1; a counter still needs at least one bit.
  function automatic int unsigned safe_clog2(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/bleeper_ms_tick.sv
// bleeper_ms_tick: ce-driven millisecond prescaler.
//   clk_sys  in   system clock
//   reset    in   synchronous active-high reset (loads MS_DIV-1)
//   ce       in   clock enable; the prescaler only counts on ce
//   reload   in   synchronous reload to MS_DIV-1 (wins over counting)
//   tick     out  high for the ce cycle in which the prescaler is 0
module bleeper_ms_tick
  import bleeper_pkg::*;
#(
  parameter int unsigned MS_DIV = 64000,
  parameter int unsigned PW     = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ce,
  input  logic reload,
  output logic tick
);

  localparam logic [PW-1:0] RELOAD_VAL = PW'(MS_DIV - 1);

  logic [PW-1:0] cnt_q;

  always_ff @(posedge clk_sys) begin
    if (reset || reload) begin
      cnt_q <= RELOAD_VAL;
    end else if (ce) begin
      cnt_q <= (cnt_q == '0) ? RELOAD_VAL : cnt_q - 1'b1;
    end
  end

  // tick does not depend on reload: the FSM derives reload from tick.
  assign tick = ce && (cnt_q == '0);

endmodule

// File: rtl/bleeper_ctrl.sv
// bleeper_ctrl: sequences the square-wave bleeper between CPU port F8
// commands and a timed keyclick, and gates the free-running tone onto the
// speaker output.
//   clk_sys    in   system clock
//   reset      in   synchronous active-high reset
//   ce         in   clock enable for all timing (not the speaker register)
//   io_wr      in   1-cycle port F8 write strobe
//   io_data    in   port F8 write data (0B = beep on, 0C = beep off)
//   click_req  in   level request for a timed click, held until click_ack
//   click_ack  out  1-cycle acceptance pulse for click_req
//   tone_in    in   square wave from the tone generator
//   speaker    out  registered tone_in & gate
//   busy       out  high whenever the FSM is not IDLE
// Build option: define BLEEPER_CLICK_EN to include the click path and the
// TIMED state; without it click_req is ignored and click_ack stays 0.
module bleeper_ctrl
  import bleeper_pkg::*;
#(
  parameter int unsigned CE_HZ    = 64000000,
  parameter int unsigned CLICK_MS = 20,
  parameter int unsigned GAP_MS   = 5
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic       io_wr,
  input  logic [7:0] io_data,
  input  logic       click_req,
  output logic       click_ack,
  input  logic       tone_in,
  output logic       speaker,
  output logic       busy
);

  localparam int unsigned MS_DIV = CE_HZ / 1000;
  localparam int unsigned PW     = safe_clog2(MS_DIV);
  localparam int unsigned DW     = safe_clog2(max_u(CLICK_MS, GAP_MS) + 1);

  localparam logic [DW-1:0] GAP_LD = DW'(GAP_MS);
`ifdef BLEEPER_CLICK_EN
  localparam logic [DW-1:0] CLICK_LD = DW'(CLICK_MS);
`endif

  bleep_state_t  state_q, state_d;
  logic [DW-1:0] dur_q, dur_ld;
  logic          load_dur;
  logic          ms_tick;
  logic          dur_last;
  logic          gate;
  logic          ack_d;
  logic          cmd_on, cmd_off;

  assign cmd_on  = io_wr && (io_data == BEEP_ON_CMD);
  assign cmd_off = io_wr && (io_data == BEEP_OFF_CMD);

  // Entering TIMED or GAP restarts the ms grid so a phase is exactly N ms.
  bleeper_ms_tick #(
    .MS_DIV (MS_DIV),
    .PW     (PW)
  ) u_ms_tick (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce      (ce),
    .reload  (load_dur),
    .tick    (ms_tick)
  );

  // The phase ends on the tick that takes the counter from 1 to 0.
  assign dur_last = (dur_q <= DW'(1));

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    load_dur = 1'b0;
    dur_ld   = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_on) begin
          state_d = CPU_ON;
        end
`ifdef BLEEPER_CLICK_EN
        else if (click_req) begin
          state_d  = TIMED;
          ack_d    = 1'b1;
          load_dur = 1'b1;
          dur_ld   = CLICK_LD;
        end
`endif
      end
      CPU_ON: begin
        if (cmd_off) begin
          state_d  = GAP;
          load_dur = 1'b1;
          dur_ld   = GAP_LD;
        end
      end
`ifdef BLEEPER_CLICK_EN
      TIMED: begin
        if (cmd_on) begin
          state_d = CPU_ON;
        end else if (cmd_off || (ms_tick && dur_last)) begin
          state_d  = GAP;
          load_dur = 1'b1;
          dur_ld   = GAP_LD;
        end
      end
`endif
      GAP: begin
        if (cmd_on) begin
          state_d = CPU_ON;
        end else if (ms_tick && dur_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dur_q <= '0;
    end else if (load_dur) begin
      dur_q <= dur_ld;
    end else if (ms_tick && (state_q == GAP || state_q == TIMED)) begin
      dur_q <= dur_q - 1'b1;
    end
  end

`ifdef BLEEPER_CLICK_EN
  assign gate = (state_q == CPU_ON) || (state_q == TIMED);
`else
  logic unused_click;
  assign unused_click = click_req;
  assign gate = (state_q == CPU_ON);
`endif

  // The gate only moves with the state register, so the speaker never glitches.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      speaker <= 1'b0;
    end else begin
      speaker <= tone_in & gate;
    end
  end

  assign click_ack = ack_d && !reset;

endmodule
